// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: right-of-way sequencer for a four-approach intersection.
// Phases GO -> CAUTION -> ALL_RED; round-robin grants, emergency requests preempt.
// Optional macro TRAFFIC_EMERG_LATCH_EN: sticky emergency latch so single-cycle pulses are served.
module traffic_phase_scheduler #(
  parameter int GO_CYCLES      = 8,
  parameter int CAUTION_CYCLES = 3,
  parameter int ALLRED_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] car_waiting,
  input  logic [3:0] emergency,
  output logic [1:0] grant_path,
  output logic       grant_valid,
  output logic [1:0] phase,
  output logic       preempt_active
);

  localparam int MAX_GC   = (GO_CYCLES > CAUTION_CYCLES) ? GO_CYCLES : CAUTION_CYCLES;
  localparam int MAX_CYC  = (MAX_GC > ALLRED_CYCLES) ? MAX_GC : ALLRED_CYCLES;
  localparam int TW       = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] T_GO      = TW'(GO_CYCLES);
  localparam logic [TW-1:0] T_CAUTION = TW'(CAUTION_CYCLES);
  localparam logic [TW-1:0] T_ALLRED  = TW'(ALLRED_CYCLES);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  typedef enum logic [1:0] {
    PH_GO      = 2'd0,
    PH_CAUTION = 2'd1,
    PH_ALLRED  = 2'd2
  } phase_t;

  phase_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    last_served;

  logic [3:0]    eff_emerg;
  logic [3:0]    path_mask;
  logic          own_emerg;
  logic          other_emerg;
  logic          emerg_any;
  logic [1:0]    emerg_sel;
  logic          rr_any;
  logic [1:0]    rr_sel;
  logic [1:0]    rr_idx;
  logic          caution_done;

  // The phase output is the state register itself, so it is registered by construction.
  assign phase = state;

  // Last CAUTION cycle: the granted path is about to release right-of-way.
  assign caution_done = (state == PH_CAUTION) && (timer == T_ONE);

  assign path_mask = 4'b0001 << grant_path;

`ifdef TRAFFIC_EMERG_LATCH_EN
  logic [3:0] emerg_latch;

  // Sticky emergency bits; a path's bit is dropped once that path finishes CAUTION.
  always_ff @(posedge clk) begin
    if (!reset) begin
      emerg_latch <= 4'b0000;
    end else begin
      emerg_latch <= (emerg_latch | emergency) & ~(caution_done ? path_mask : 4'b0000);
    end
  end

  assign eff_emerg = emerg_latch | emergency;
`else
  assign eff_emerg = emergency;
`endif

  assign own_emerg   = |(eff_emerg & path_mask);
  assign other_emerg = |(eff_emerg & ~path_mask);
  assign emerg_any   = |eff_emerg;

  // Emergency selection: lowest set index wins.
  always_comb begin
    emerg_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eff_emerg[i]) emerg_sel = 2'(i);
    end
  end

  // Round-robin search starting just after the last served path; descending loop so the nearest hit wins.
  always_comb begin
    rr_any = 1'b0;
    rr_sel = 2'd0;
    rr_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      rr_idx = last_served + 2'(k);
      if (car_waiting[rr_idx]) begin
        rr_any = 1'b1;
        rr_sel = rr_idx;
      end
    end
  end

  // Phase sequencer: timer loads on phase entry, counts down, and expires at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= PH_ALLRED;
      timer          <= '0;
      grant_path     <= 2'd0;
      grant_valid    <= 1'b0;
      preempt_active <= 1'b0;
      last_served    <= 2'd3;
    end else begin
      case (state)
        PH_ALLRED: begin
          // Timer at zero means the minimum red hold is over; select every cycle from then on.
          if (timer != '0) begin
            timer <= timer - T_ONE;
          end else if (emerg_any) begin
            state          <= PH_GO;
            timer          <= T_GO;
            grant_path     <= emerg_sel;
            grant_valid    <= 1'b1;
            preempt_active <= 1'b1;
          end else if (rr_any) begin
            state          <= PH_GO;
            timer          <= T_GO;
            grant_path     <= rr_sel;
            grant_valid    <= 1'b1;
            preempt_active <= 1'b0;
          end
        end

        PH_GO: begin
          if (other_emerg && !own_emerg) begin
            // Another approach has an emergency and ours does not: yield early.
            state <= PH_CAUTION;
            timer <= T_CAUTION;
          end else if (timer == T_ONE) begin
            // At expiry an emergency on our own path holds GO; timer parks at 1.
            if (!own_emerg) begin
              state <= PH_CAUTION;
              timer <= T_CAUTION;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end

        PH_CAUTION: begin
          if (timer == T_ONE) begin
            state          <= PH_ALLRED;
            timer          <= T_ALLRED;
            grant_valid    <= 1'b0;
            preempt_active <= 1'b0;
            last_served    <= grant_path;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        default: begin
          state          <= PH_ALLRED;
          timer          <= T_ALLRED;
          grant_valid    <= 1'b0;
          preempt_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus randomized traffic
// compared against a phase/age reference model.
module tb_traffic_phase_scheduler;

  localparam int GO = 8;
  localparam int CA = 3;
  localparam int AR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] car_waiting;
  logic [3:0] emergency;
  logic [1:0] grant_path;
  logic       grant_valid;
  logic [1:0] phase;
  logic       preempt_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: phase (0 GO,1 CAUTION,2 ALL_RED) and age = cycles spent in it including this one.
  int         m_phase;
  int         m_age;
  int         m_path;
  int         m_pre;
  int         m_last;
  logic [3:0] m_latch;

  traffic_phase_scheduler #(
    .GO_CYCLES(GO), .CAUTION_CYCLES(CA), .ALLRED_CYCLES(AR)
  ) dut (
    .clk(clk), .reset(reset), .car_waiting(car_waiting), .emergency(emergency),
    .grant_path(grant_path), .grant_valid(grant_valid), .phase(phase),
    .preempt_active(preempt_active)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [3:0] eff;
    logic [3:0] clr;
    int sel;
    bit found;
    bit own;
    bit others;
    if (!reset) begin
      m_phase = 2; m_age = AR + 1; m_path = 0; m_pre = 0; m_last = 3; m_latch = 4'b0;
      return;
    end
`ifdef TRAFFIC_EMERG_LATCH_EN
    eff = m_latch | emergency;
`else
    eff = emergency;
`endif
    clr = 4'b0; sel = 0; found = 0;
    case (m_phase)
      2: begin
        if (m_age > AR) begin
          if (eff != 4'b0) begin
            for (int i = 3; i >= 0; i--) if (eff[i]) sel = i;
            found = 1; m_pre = 1;
          end else if (car_waiting != 4'b0) begin
            for (int k = 1; k <= 4; k++)
              if (!found && car_waiting[(m_last + k) % 4]) begin sel = (m_last + k) % 4; found = 1; end
            m_pre = 0;
          end
          if (found) begin m_phase = 0; m_age = 1; m_path = sel; end
          else m_age++;
        end else m_age++;
      end
      0: begin
        own = eff[m_path];
        others = 0;
        for (int i = 0; i < 4; i++) if (i != m_path && eff[i]) others = 1;
        if ((others && !own) || (m_age >= GO && !own)) begin m_phase = 1; m_age = 1; end
        else m_age++;
      end
      default: begin
        if (m_age == CA) begin
          m_phase = 2; m_age = 1; m_last = m_path; m_pre = 0; clr[m_path] = 1'b1;
        end else m_age++;
      end
    endcase
`ifdef TRAFFIC_EMERG_LATCH_EN
    m_latch = (m_latch | emergency) & ~clr;
`endif
  endtask

  // One clock: DUT and model advance on the edge; caller resumes at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_for(input int ph, input int path, input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (phase == 2'(ph) && (path < 0 || grant_path == 2'(path))) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; car_waiting = 4'b0; emergency = 4'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; car_waiting = 4'b0; emergency = 4'b0;
    tick(); tick();
    checks++;
    if (phase !== 2'd2 || grant_valid !== 1'b0 || preempt_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: phase=%0d valid=%0b pre=%0b, want phase=2 valid=0 pre=0", phase, grant_valid, preempt_active);
    end
    reset = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      checks++;
      if (phase !== 2'd2 || grant_valid !== 1'b0 || grant_path !== 2'd0) begin
        failures++;
        $display("FAIL idle_cycle%0d: phase=%0d valid=%0b path=%0d, want 2/0/0", n, phase, grant_valid, grant_path);
      end
    end
  endtask

  task automatic test_round_robin();
    int starts[$];
    int paths[$];
    int go_runs[$];
    int ca_runs[$];
    int ar_runs[$];
    int run;
    logic [1:0] prev;
    do_reset();
    car_waiting = 4'b1111;
    prev = phase; run = 0;
    for (int n = 0; n < 120 && paths.size() < 6; n++) begin
      tick();
      checks++;
      if (phase !== 2'(m_phase) || grant_path !== 2'(m_path)) begin
        failures++;
        $display("FAIL rr_model c%0d: phase=%0d path=%0d, want %0d/%0d", cyc, phase, grant_path, m_phase, m_path);
      end
      if (phase == prev) run++;
      else begin
        if (prev == 2'd0) go_runs.push_back(run);
        if (prev == 2'd1) ca_runs.push_back(run);
        if (prev == 2'd2 && starts.size() > 0) ar_runs.push_back(run);
        if (phase == 2'd0) begin starts.push_back(cyc); paths.push_back(int'(grant_path)); end
        prev = phase; run = 1;
      end
    end
    checks++;
    if (paths.size() < 5) begin
      failures++;
      $display("FAIL rr_grant_count: got %0d grants, want at least 5", paths.size());
    end
    for (int i = 0; i < 5 && i < paths.size(); i++) begin
      checks++;
      if (paths[i] != i % 4) begin
        failures++;
        $display("FAIL rr_seq%0d: path=%0d, want %0d", i, paths[i], i % 4);
      end
    end
    for (int i = 0; i + 1 < starts.size() && i < 4; i++) begin
      checks++;
      if (starts[i+1] - starts[i] != GO + CA + AR + 1) begin
        failures++;
        $display("FAIL rr_period%0d: %0d cycles, want %0d", i, starts[i+1] - starts[i], GO + CA + AR + 1);
      end
    end
    for (int i = 0; i < go_runs.size() && i < 4; i++) begin
      checks++;
      if (go_runs[i] != GO || ca_runs[i] != CA) begin
        failures++;
        $display("FAIL rr_len%0d: go=%0d caution=%0d, want %0d/%0d", i, go_runs[i], ca_runs[i], GO, CA);
      end
    end
    for (int i = 0; i < ar_runs.size() && i < 4; i++) begin
      checks++;
      if (ar_runs[i] != AR + 1) begin
        failures++;
        $display("FAIL rr_allred%0d: %0d cycles, want %0d", i, ar_runs[i], AR + 1);
      end
    end
  endtask

  task automatic test_preempt();
    bit ok;
    do_reset();
    car_waiting = 4'b0001;
    wait_for(0, 0, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL preempt_first_grant: timeout, phase=%0d path=%0d", phase, grant_path); end
    tick(); tick();
    emergency = 4'b0100;
    tick();
    checks++;
    if (phase !== 2'd1) begin failures++; $display("FAIL preempt_early_exit: phase=%0d, want 1", phase); end
    wait_for(0, -1, 40, ok);
    checks++;
    if (!ok || grant_path !== 2'd2 || preempt_active !== 1'b1) begin
      failures++;
      $display("FAIL preempt_grant: ok=%0b path=%0d pre=%0b, want path=2 pre=1", ok, grant_path, preempt_active);
    end
    emergency = 4'b0;
  endtask

  task automatic test_extension();
    int go_len;
    bit ok;
    do_reset();
    car_waiting = 4'b0010;
    emergency   = 4'b0010;
    go_len = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (phase == 2'd0) go_len++;
    end
    emergency   = 4'b0;
    car_waiting = 4'b1111;
    for (int n = 0; n < 40 && phase == 2'd0; n++) begin
      tick();
      if (phase == 2'd0) go_len++;
    end
    checks++;
    if (go_len != 20 || phase !== 2'd1) begin
      failures++;
      $display("FAIL ext_go_len: go=%0d then phase=%0d, want 20 then 1", go_len, phase);
    end
    wait_for(0, -1, 40, ok);
    checks++;
    if (!ok || grant_path !== 2'd2 || preempt_active !== 1'b0) begin
      failures++;
      $display("FAIL ext_next_rr: ok=%0b path=%0d pre=%0b, want path=2 pre=0", ok, grant_path, preempt_active);
    end
  endtask

  task automatic test_reset_mid_go();
    bit ok;
    wait_for(0, 2, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midgo_reach: timeout waiting GO on path 2, path=%0d", grant_path); end
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (phase !== 2'd2 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL midgo_abort: phase=%0d valid=%0b, want 2/0", phase, grant_valid);
    end
    reset = 1'b1;
    wait_for(0, -1, 40, ok);
    checks++;
    if (!ok || grant_path !== 2'd0) begin
      failures++;
      $display("FAIL midgo_regrant: ok=%0b path=%0d, want 0", ok, grant_path);
    end
  endtask

  task automatic test_emerg_pulse();
    bit ok;
    do_reset();
    car_waiting = 4'b0001;
    wait_for(0, 0, 40, ok);
    wait_for(2, -1, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pulse_allred: timeout, phase=%0d", phase); end
    emergency = 4'b1000;
    tick();
    emergency = 4'b0000;
    wait_for(0, -1, 40, ok);
    checks++;
`ifdef TRAFFIC_EMERG_LATCH_EN
    if (!ok || grant_path !== 2'd3 || preempt_active !== 1'b1) begin
      failures++;
      $display("FAIL pulse_grant: ok=%0b path=%0d pre=%0b, want path=3 pre=1", ok, grant_path, preempt_active);
    end
`else
    if (!ok || grant_path !== 2'd0 || preempt_active !== 1'b0) begin
      failures++;
      $display("FAIL pulse_grant: ok=%0b path=%0d pre=%0b, want path=0 pre=0", ok, grant_path, preempt_active);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      checks++;
      if (phase !== 2'(m_phase) || grant_path !== 2'(m_path) ||
          grant_valid !== (m_phase != 2) || preempt_active !== (m_pre != 0)) begin
        failures++;
        $display("FAIL rand_c%0d: phase=%0d path=%0d valid=%0b pre=%0b, want %0d/%0d/%0b/%0d",
                 cyc, phase, grant_path, grant_valid, preempt_active, m_phase, m_path, (m_phase != 2), m_pre);
      end
      car_waiting = 4'($urandom);
      if ($urandom_range(0, 15) == 0) emergency = 4'($urandom);
      else if ($urandom_range(0, 5) == 0) emergency = 4'b0;
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    reset = 1'b1; emergency = 4'b0;
  endtask

  initial begin
    reset = 1'b0; car_waiting = 4'b0; emergency = 4'b0;
    m_phase = 2; m_age = AR + 1; m_path = 0; m_pre = 0; m_last = 3; m_latch = 4'b0;
    test_reset();
    test_round_robin();
    test_preempt();
    test_extension();
    test_reset_mid_go();
    test_emerg_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
